// File: rtl/execute_stage.sv
// execute_stage: EX stage of the five-stage pipeline.
//   Picks forwarded operands, runs the ALU, and updates the {C,N,Z} condition codes.
//   Registers the result and destination number for the execute/memory register.
//   Optional MUL support is built when EX_MUL_EN is defined. It is an iterative unsigned
//   shift-add multiplier that raises stall_out while it runs. Without EX_MUL_EN, MUL acts as
//   NOP and stall_out/mul_hi_out are tied to 0.
// Ports:
//   clk, reset (sync, active-high), en (stage enable), flush (squash, beats en)
//   valid_in, alu_op, reg_dst_num_in      instruction from decode/execute register
//   src1_value, src2_value, imm_value     operands; use_imm replaces B after forwarding
//   fwd_sel_1/2, em_fwd_value, mw_fwd_value  forwarding selects and sources
//   result_out, mul_hi_out, reg_dst_out, valid_out  registered stage outputs
//   ccr_out {C,N,Z}, stall_out (multiplier busy)
module execute_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MUL_ITER = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        alu_op,
  input  logic [2:0]        reg_dst_num_in,
  input  logic [DATA_W-1:0] src1_value,
  input  logic [DATA_W-1:0] src2_value,
  input  logic [DATA_W-1:0] imm_value,
  input  logic              use_imm,
  input  logic [1:0]        fwd_sel_1,
  input  logic [1:0]        fwd_sel_2,
  input  logic [DATA_W-1:0] em_fwd_value,
  input  logic [DATA_W-1:0] mw_fwd_value,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] mul_hi_out,
  output logic [2:0]        reg_dst_out,
  output logic              valid_out,
  output logic [2:0]        ccr_out,
  output logic              stall_out
);

  localparam logic [3:0] OpMov  = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpNot  = 4'd6;
  localparam logic [3:0] OpInc  = 4'd7;
  localparam logic [3:0] OpDec  = 4'd8;
  localparam logic [3:0] OpShl  = 4'd9;
  localparam logic [3:0] OpShr  = 4'd10;
  localparam logic [3:0] OpSetc = 4'd11;
  localparam logic [3:0] OpClrc = 4'd12;

  // The shift-add loop produces a full product only with one iteration per operand bit.
  if (MUL_ITER != DATA_W) begin : g_mul_iter_check
    $error("MUL_ITER must equal DATA_W");
  end

  logic [DATA_W-1:0] result_q;
  logic [2:0]        dst_q;
  logic              valid_q;
  logic [2:0]        ccr_q;
  logic [2:0]        ccr_d;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   wide;
  logic [3:0]        shamt;
  logic              alu_c;
  logic              upd_zn;
  logic              upd_c;
  logic              take_alu;

  // Operand selection: forwarding first, then the immediate overrides B.
  always_comb begin
    unique case (fwd_sel_1)
      2'd1:    op_a = em_fwd_value;
      2'd2:    op_a = mw_fwd_value;
      default: op_a = src1_value;
    endcase
    unique case (fwd_sel_2)
      2'd1:    op_b = em_fwd_value;
      2'd2:    op_b = mw_fwd_value;
      default: op_b = src2_value;
    endcase
    if (use_imm) op_b = imm_value;
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    upd_zn  = 1'b0;
    upd_c   = 1'b0;
    wide    = '0;
    shamt   = op_b[3:0];
    case (alu_op)
      OpMov: alu_res = op_b;
      OpAdd: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OpSub: begin
        // Bit DATA_W of the widened difference is the unsigned borrow.
        wide    = {1'b0, op_a} - {1'b0, op_b};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OpAnd: begin
        alu_res = op_a & op_b;
        upd_zn  = 1'b1;
      end
      OpOr: begin
        alu_res = op_a | op_b;
        upd_zn  = 1'b1;
      end
      OpNot: begin
        alu_res = ~op_a;
        upd_zn  = 1'b1;
      end
      OpInc: begin
        wide    = {1'b0, op_a} + (DATA_W+1)'(1);
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OpDec: begin
        wide    = {1'b0, op_a} - (DATA_W+1)'(1);
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OpShl: begin
        upd_zn = 1'b1;
        if (shamt == 4'd0) begin
          alu_res = op_a;
        end else begin
          // The last bit shifted out lands in the extra top bit.
          wide    = {1'b0, op_a} << shamt;
          alu_res = wide[DATA_W-1:0];
          alu_c   = wide[DATA_W];
          upd_c   = 1'b1;
        end
      end
      OpShr: begin
        upd_zn = 1'b1;
        if (shamt == 4'd0) begin
          alu_res = op_a;
        end else begin
          wide    = {op_a, 1'b0} >> shamt;
          alu_res = wide[DATA_W:1];
          alu_c   = wide[0];
          upd_c   = 1'b1;
        end
      end
      OpSetc: begin
        alu_c = 1'b1;
        upd_c = 1'b1;
      end
      OpClrc: begin
        alu_c = 1'b0;
        upd_c = 1'b1;
      end
      default: alu_res = '0;
    endcase
    ccr_d[2] = upd_c  ? alu_c                 : ccr_q[2];
    ccr_d[1] = upd_zn ? alu_res[DATA_W-1]     : ccr_q[1];
    ccr_d[0] = upd_zn ? (alu_res == '0)       : ccr_q[0];
  end

`ifdef EX_MUL_EN
  localparam logic [3:0]  OpMul = 4'd13;
  localparam int unsigned CntW  = $clog2(MUL_ITER + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   mul_hi_q;
  logic                stall_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   acc_hi_q;
  logic [DATA_W-1:0]   acc_lo_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [DATA_W:0]     step_sum;
  logic [2*DATA_W-1:0] prod_d;

  // acc_lo_q starts as the multiplier and fills with product bits as it shifts right.
  always_comb begin
    step_sum = {1'b0, acc_hi_q};
    if (acc_lo_q[0]) step_sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    prod_d   = {step_sum, acc_lo_q[DATA_W-1:1]};
    take_alu = (state_q == StIdle) && !(valid_in && alu_op == OpMul);
  end

  assign mul_hi_out = mul_hi_q;
  assign stall_out  = stall_q;
`else
  assign take_alu   = 1'b1;
  assign mul_hi_out = '0;
  assign stall_out  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      dst_q    <= '0;
      valid_q  <= 1'b0;
      ccr_q    <= '0;
`ifdef EX_MUL_EN
      state_q  <= StIdle;
      mul_hi_q <= '0;
      stall_q  <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
`endif
    end else if (flush) begin
      valid_q <= 1'b0;
`ifdef EX_MUL_EN
      state_q <= StIdle;
      stall_q <= 1'b0;
`endif
    end else if (en) begin
      if (take_alu) begin
        valid_q <= valid_in;
        if (valid_in) begin
          result_q <= alu_res;
          dst_q    <= reg_dst_num_in;
          ccr_q    <= ccr_d;
`ifdef EX_MUL_EN
          mul_hi_q <= '0;
`endif
        end
      end
`ifdef EX_MUL_EN
      else if (state_q == StBusy) begin
        acc_hi_q <= prod_d[2*DATA_W-1:DATA_W];
        acc_lo_q <= prod_d[DATA_W-1:0];
        cnt_q    <= cnt_q + CntW'(1);
        if (cnt_q == CntW'(MUL_ITER - 1)) begin
          result_q <= prod_d[DATA_W-1:0];
          mul_hi_q <= prod_d[2*DATA_W-1:DATA_W];
          valid_q  <= 1'b1;
          stall_q  <= 1'b0;
          state_q  <= StIdle;
          ccr_q[1] <= prod_d[2*DATA_W-1];
          ccr_q[0] <= (prod_d == '0);
        end
      end else begin
        // MUL accepted in idle.
        acc_hi_q <= '0;
        acc_lo_q <= op_a;
        mcand_q  <= op_b;
        dst_q    <= reg_dst_num_in;
        cnt_q    <= '0;
        valid_q  <= 1'b0;
        stall_q  <= 1'b1;
        state_q  <= StBusy;
      end
`endif
    end
  end

  assign result_out  = result_q;
  assign reg_dst_out = dst_q;
  assign valid_out   = valid_q;
  assign ccr_out     = ccr_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed steps followed by a randomized run.
// A behavioural model predicts every output after each clock edge.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flush;
  logic        valid_in;
  logic [3:0]  alu_op;
  logic [2:0]  reg_dst_num_in;
  logic [15:0] src1_value;
  logic [15:0] src2_value;
  logic [15:0] imm_value;
  logic        use_imm;
  logic [1:0]  fwd_sel_1;
  logic [1:0]  fwd_sel_2;
  logic [15:0] em_fwd_value;
  logic [15:0] mw_fwd_value;
  logic [15:0] result_out;
  logic [15:0] mul_hi_out;
  logic [2:0]  reg_dst_out;
  logic        valid_out;
  logic [2:0]  ccr_out;
  logic        stall_out;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(16), .MUL_ITER(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .flush          (flush),
    .valid_in       (valid_in),
    .alu_op         (alu_op),
    .reg_dst_num_in (reg_dst_num_in),
    .src1_value     (src1_value),
    .src2_value     (src2_value),
    .imm_value      (imm_value),
    .use_imm        (use_imm),
    .fwd_sel_1      (fwd_sel_1),
    .fwd_sel_2      (fwd_sel_2),
    .em_fwd_value   (em_fwd_value),
    .mw_fwd_value   (mw_fwd_value),
    .result_out     (result_out),
    .mul_hi_out     (mul_hi_out),
    .reg_dst_out    (reg_dst_out),
    .valid_out      (valid_out),
    .ccr_out        (ccr_out),
    .stall_out      (stall_out)
  );

`ifdef EX_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state.
  logic [15:0] m_res  = '0;
  logic [15:0] m_hi   = '0;
  logic [2:0]  m_dst  = '0;
  logic        m_valid = 1'b0;
  logic        m_c = 1'b0, m_n = 1'b0, m_z = 1'b0;
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_prod = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] src);
    if (sel == 2'd1) return em_fwd_value;
    if (sel == 2'd2) return mw_fwd_value;
    return src;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int unsigned a, b, s, r;
    logic        zn;
    a = pick(fwd_sel_1, src1_value);
    b = use_imm ? imm_value : pick(fwd_sel_2, src2_value);
    if (reset) begin
      m_res = '0; m_hi = '0; m_dst = '0; m_valid = 1'b0;
      m_c = 1'b0; m_n = 1'b0; m_z = 1'b0; m_busy = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end else if (en) begin
      if (m_busy) begin
        m_left--;
        m_valid = 1'b0;
        if (m_left == 0) begin
          m_busy  = 1'b0;
          m_valid = 1'b1;
          m_res   = m_prod[15:0];
          m_hi    = m_prod[31:16];
          m_z     = (m_prod == 0);
          m_n     = m_prod[31];
        end
      end else if (valid_in && alu_op == 4'd13 && MulEn) begin
        m_busy  = 1'b1;
        m_left  = 16;
        m_prod  = a * b;
        m_dst   = reg_dst_num_in;
        m_valid = 1'b0;
      end else begin
        m_valid = valid_in;
        if (valid_in) begin
          r  = 0;
          zn = 1'b1;
          s  = b % 16;
          case (alu_op)
            4'd1:  begin r = b; zn = 1'b0; end
            4'd2:  begin r = a + b; m_c = (r > 32'hFFFF); end
            4'd3:  begin r = a - b; m_c = (a < b); end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = ~a;
            4'd7:  begin r = a + 1; m_c = (a == 32'hFFFF); end
            4'd8:  begin r = a - 1; m_c = (a == 0); end
            4'd9:  if (s == 0) r = a;
                   else begin r = a << s; m_c = ((a >> (16 - s)) & 1) != 0; end
            4'd10: if (s == 0) r = a;
                   else begin r = a >> s; m_c = ((a >> (s - 1)) & 1) != 0; end
            4'd11: begin m_c = 1'b1; zn = 1'b0; end
            4'd12: begin m_c = 1'b0; zn = 1'b0; end
            default: zn = 1'b0;
          endcase
          m_res = r[15:0];
          m_hi  = '0;
          m_dst = reg_dst_num_in;
          if (zn) begin
            m_z = (r[15:0] == 16'h0);
            m_n = r[15];
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("result", 32'(result_out), 32'(m_res));
    chk("mul_hi", 32'(mul_hi_out), 32'(m_hi));
    chk("reg_dst", 32'(reg_dst_out), 32'(m_dst));
    chk("valid", 32'(valid_out), 32'(m_valid));
    chk("ccr", 32'(ccr_out), 32'({m_c, m_n, m_z}));
    chk("stall", 32'(stall_out), 32'(m_busy));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] dst);
    valid_in = 1'b1; alu_op = op; src1_value = a; src2_value = b; reg_dst_num_in = dst;
    fwd_sel_1 = 2'd0; fwd_sel_2 = 2'd0; use_imm = 1'b0;
  endtask

  function automatic logic [15:0] rnd_val();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k == 0) return 16'h0000;
    if (k == 1) return 16'hFFFF;
    if (k == 2) return 16'h8000;
    if (k == 3) return 16'(($urandom_range(0, 17)));
    return 16'($urandom);
  endfunction

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    set_op(4'd0, 16'h0, 16'h0, 3'd0);
    valid_in = 1'b0; imm_value = '0; em_fwd_value = '0; mw_fwd_value = '0;

    // T1: reset then ADD with carry-out to zero.
    tick(); tick();
    chk("rst_result", 32'(result_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_ccr", 32'(ccr_out), 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    reset = 1'b0;
    set_op(4'd2, 16'hFFFF, 16'h0001, 3'd3);
    tick();
    chk("t1_add", 32'(result_out), 32'h0000);
    chk("t1_ccr", 32'(ccr_out), 32'b101);
    chk("t1_dst", 32'(reg_dst_out), 32'd3);

    // T2: SUB with A forwarded from execute/memory.
    set_op(4'd3, 16'h7777, 16'h0005, 3'd4);
    fwd_sel_1 = 2'd1; em_fwd_value = 16'h0003;
    tick();
    chk("t2_sub", 32'(result_out), 32'hFFFE);
    chk("t2_ccr", 32'(ccr_out), 32'b110);

    // T3: shifts, SETC then AND.
    set_op(4'd9, 16'h8001, 16'h0000, 3'd1);
    use_imm = 1'b1; imm_value = 16'h0001;
    tick();
    chk("t3_shl", 32'(result_out), 32'h0002);
    chk("t3_shl_c", 32'(ccr_out[2]), 32'h1);
    set_op(4'd10, 16'h00F0, 16'h0010, 3'd2);
    tick();
    chk("t3_shr0", 32'(result_out), 32'h00F0);
    chk("t3_shr0_c", 32'(ccr_out[2]), 32'h1);
    set_op(4'd12, 16'h0, 16'h0, 3'd2);
    tick();
    set_op(4'd11, 16'h0, 16'h0, 3'd2);
    tick();
    set_op(4'd5, 16'h0F0F, 16'h00FF, 3'd5);
    set_op(4'd4, 16'h0F0F, 16'h00FF, 3'd5);
    tick();
    chk("t3_and", 32'(result_out), 32'h000F);
    chk("t3_and_ccr", 32'(ccr_out), 32'b100);

    // T4: enable low freezes everything; flush still squashes.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(4'($urandom_range(1, 10)), 16'($urandom), 16'($urandom), 3'd6);
      tick();
      chk("t4_frozen", 32'(result_out), 32'h000F);
    end
    flush = 1'b1;
    tick();
    chk("t4_flush_valid", 32'(valid_out), 32'h0);
    flush = 1'b0; en = 1'b1;

`ifdef EX_MUL_EN
    // T5: 16-cycle multiply.
    set_op(4'd13, 16'h1234, 16'h0100, 3'd7);
    tick();
    chk("t5_stall0", 32'(stall_out), 32'h1);
    set_op(4'd2, 16'h1111, 16'h2222, 3'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_stall", 32'(stall_out), 32'h1);
    end
    valid_in = 1'b0;
    tick();
    chk("t5_lo", 32'(result_out), 32'h3400);
    chk("t5_hi", 32'(mul_hi_out), 32'h0012);
    chk("t5_valid", 32'(valid_out), 32'h1);
    chk("t5_stall_end", 32'(stall_out), 32'h0);

    // T6: flush partway through a multiply, then a normal ADD.
    set_op(4'd13, 16'hABCD, 16'h1234, 3'd2);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    chk("t6_stall", 32'(stall_out), 32'h0);
    chk("t6_valid", 32'(valid_out), 32'h0);
    flush = 1'b0;
    set_op(4'd2, 16'h0010, 16'h0020, 3'd3);
    tick();
    chk("t6_add", 32'(result_out), 32'h0030);
    chk("t6_add_valid", 32'(valid_out), 32'h1);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      flush          = ($urandom_range(0, 24) == 0);
      en             = ($urandom_range(0, 7) != 0);
      valid_in       = ($urandom_range(0, 4) != 0);
      alu_op         = 4'($urandom_range(0, 15));
      reg_dst_num_in = 3'($urandom);
      src1_value     = rnd_val();
      src2_value     = rnd_val();
      imm_value      = rnd_val();
      use_imm        = ($urandom_range(0, 3) == 0);
      fwd_sel_1      = 2'($urandom);
      fwd_sel_2      = 2'($urandom);
      em_fwd_value   = rnd_val();
      mw_fwd_value   = rnd_val();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
